// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial add/subtract unit.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adder_state_t;

  // True when DIGIT is a legal slice size for a WIDTH-bit operand.
  function automatic bit digits_ok(input int width, input int digit);
    return (digit > 0) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a client and the serial adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple of full adders; also exposes the carry
// entering the top bit so the caller can derive signed overflow.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] cv;

  // Ripple the carry through each full adder of the digit.
  always_comb begin
    cv    = '0;
    s     = '0;
    cv[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]    = x[i] ^ y[i] ^ cv[i];
      cv[i+1] = (x[i] & y[i]) | (x[i] & cv[i]) | (y[i] & cv[i]);
    end
    co    = cv[DIGIT];
    c_msb = cv[DIGIT-1];
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract engine: one DIGIT-bit slice per clock, carry held
// in a register between slices, result published with a one-cycle done pulse.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (!digits_ok(WIDTH, DIGIT) || (WIDTH < 2)) begin : g_bad_params
    $error("serial_adder: WIDTH must be >= 2 and divisible by DIGIT");
  end

  adder_state_t     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0]       dig_s;
  logic                   dig_co;
  logic                   dig_cmsb;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_shift;
  logic                   last_digit;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x     (opa_q[DIGIT-1:0]),
    .y     (opb_q[DIGIT-1:0]),
    .ci    (carry_q),
    .s     (dig_s),
    .co    (dig_co),
    .c_msb (dig_cmsb)
  );

  // New digit enters at the top, so after NDIG slices the LSB digit sits at bit 0.
  assign res_cat    = {dig_s, res_q};
  assign res_shift  = res_cat[WIDTH+DIGIT-1:DIGIT];
  assign last_digit = (cnt_q == CW'(NDIG - 1));

  // Next-state, datapath shifting and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          // Subtraction folds into addition: A + ~B + ~cin.
          opa_d   = bus.a;
          opb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.cin ^ bus.sub;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        carry_d = dig_co;
        res_d   = res_shift;
        cnt_d   = cnt_q + CW'(1);
        if (last_digit) begin
          sum_d   = res_shift;
          cout_d  = dig_co;
          ovf_d   = dig_cmsb ^ dig_co;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at DIGIT = 1, 4 and 8 (WIDTH = 8).
module tb_serial_adder;

  logic clk;
  logic rst;

  serial_adder_if #(.WIDTH(8)) s1 ();
  serial_adder_if #(.WIDTH(8)) s4 ();
  serial_adder_if #(.WIDTH(8)) s8 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) u1 (.clk(clk), .rst(rst), .bus(s1));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (.clk(clk), .rst(rst), .bus(s4));
  serial_adder #(.WIDTH(8), .DIGIT(8)) u8 (.clk(clk), .rst(rst), .bus(s8));

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected {sum, cout, overflow} per DUT, in issue order.
  logic [9:0] q1[$];
  logic [9:0] q4[$];
  logic [9:0] q8[$];
  logic [9:0] e1, e4, e8;

  logic [7:0] vals [8] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55, 8'hAA, 8'h3C};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural reference: full-width add, overflow from operand/result signs.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic sub);
    logic [7:0] bb;
    logic [8:0] r;
    logic       ovf;
    bb  = sub ? ~b : b;
    r   = {1'b0, a} + {1'b0, bb} + {8'd0, cin ^ sub};
    ovf = (a[7] == bb[7]) && (r[7] != a[7]);
    return {r[7:0], r[8], ovf};
  endfunction

  // Monitors: compare every done pulse against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (s1.done === 1'b1) begin
      if (q1.size() == 0) check("d1_unexpected_done", 32'(s1.done), 32'd0);
      else begin
        e1 = q1.pop_front();
        check("d1_result", 32'({s1.sum, s1.cout, s1.overflow}), 32'(e1));
      end
    end
  end

  always @(negedge clk) begin
    if (s4.done === 1'b1) begin
      if (q4.size() == 0) check("d4_unexpected_done", 32'(s4.done), 32'd0);
      else begin
        e4 = q4.pop_front();
        check("d4_result", 32'({s4.sum, s4.cout, s4.overflow}), 32'(e4));
      end
    end
  end

  always @(negedge clk) begin
    if (s8.done === 1'b1) begin
      if (q8.size() == 0) check("d8_unexpected_done", 32'(s8.done), 32'd0);
      else begin
        e8 = q8.pop_front();
        check("d8_result", 32'({s8.sum, s8.cout, s8.overflow}), 32'(e8));
      end
    end
  end

  // DIGIT=1 single operation, issued at a negedge; returns at the negedge of the DONE cycle.
  task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic sub, input logic [9:0] exp);
    int lat;
    int busy_cnt;
    s1.a = a; s1.b = b; s1.cin = cin; s1.sub = sub; s1.start = 1'b1;
    q1.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    s1.start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (s1.done !== 1'b1 && lat < 20) begin
      if (s1.busy === 1'b1) busy_cnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("d1_latency", 32'(lat), 32'd8);
    check("d1_busy_cycles", 32'(busy_cnt), 32'd8);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    s1.start = 1'b0; s1.a = 8'h00; s1.b = 8'h00; s1.cin = 1'b0; s1.sub = 1'b0;
    s4.start = 1'b0; s4.a = 8'h00; s4.b = 8'h00; s4.cin = 1'b0; s4.sub = 1'b0;
    s8.start = 1'b0; s8.a = 8'h00; s8.b = 8'h00; s8.cin = 1'b0; s8.sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(s1.busy), 32'd0);
    check("rst_done", 32'(s1.done), 32'd0);
    check("rst_sum", 32'(s1.sum), 32'd0);
    check("rst_cout", 32'(s1.cout), 32'd0);
    check("rst_ovf", 32'(s1.overflow), 32'd0);
    check("rst_d4_busy", 32'(s4.busy), 32'd0);
    check("rst_d8_done", 32'(s8.done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic add, carry out, signed overflow, and subtraction.
    run1(8'h00, 8'h00, 1'b0, 1'b0, {8'h00, 1'b0, 1'b0});
    run1(8'hFF, 8'h01, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0});
    run1(8'h7F, 8'h01, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1});
    run1(8'h05, 8'h07, 1'b0, 1'b1, {8'hFE, 1'b0, 1'b0});
    run1(8'h80, 8'h01, 1'b0, 1'b1, {8'h7F, 1'b1, 1'b1});
    run1(8'h10, 8'h20, 1'b1, 1'b0, {8'h31, 1'b0, 1'b0});

    // start held high through RUN with changing operands: exactly one result.
    s1.a = 8'h05; s1.b = 8'h07; s1.cin = 1'b0; s1.sub = 1'b1; s1.start = 1'b1;
    q1.push_back({8'hFE, 1'b0, 1'b0});
    @(posedge clk);
    @(negedge clk);
    s1.a = 8'hFF; s1.b = 8'h00; s1.sub = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("held_start_done", 32'(s1.done), 32'd1);
    s1.start = 1'b0;
    repeat (12) @(negedge clk);
    check("held_start_idle", 32'(s1.busy), 32'd0);

    // Back-to-back: accept in the DONE cycle, sum holds previous value during RUN.
    run1(8'h05, 8'h07, 1'b0, 1'b1, {8'hFE, 1'b0, 1'b0});
    s1.a = 8'h10; s1.b = 8'h20; s1.cin = 1'b0; s1.sub = 1'b0; s1.start = 1'b1;
    q1.push_back({8'h30, 1'b0, 1'b0});
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s1.start = 1'b0;
      check("b2b_busy", 32'(s1.busy), 32'd1);
      check("b2b_sum_hold", 32'(s1.sum), 32'hFE);
      @(posedge clk);
    end
    @(negedge clk);
    check("b2b_done", 32'(s1.done), 32'd1);

    // Reset during cycle 3 of RUN aborts without a done pulse.
    s1.a = 8'h12; s1.b = 8'h34; s1.cin = 1'b0; s1.sub = 1'b0; s1.start = 1'b1;
    @(posedge clk);
    #1 s1.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", 32'(s1.busy), 32'd0);
    check("abort_done", 32'(s1.done), 32'd0);
    check("abort_sum", 32'(s1.sum), 32'd0);
    check("abort_cout", 32'(s1.cout), 32'd0);
    check("abort_ovf", 32'(s1.overflow), 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    // DIGIT=4 and DIGIT=8 swept against the behavioural model, back-to-back.
    fork
      begin : sweep4
        int lat4;
        for (int ia = 0; ia < 8; ia++)
          for (int ib = 0; ib < 8; ib++)
            for (int c = 0; c < 2; c++)
              for (int s = 0; s < 2; s++) begin
                s4.a = vals[ia]; s4.b = vals[ib]; s4.cin = c[0]; s4.sub = s[0];
                s4.start = 1'b1;
                q4.push_back(model(vals[ia], vals[ib], c[0], s[0]));
                @(posedge clk);
                @(negedge clk);
                s4.start = 1'b0;
                lat4 = 0;
                while (s4.done !== 1'b1 && lat4 < 10) begin
                  @(posedge clk);
                  lat4++;
                  @(negedge clk);
                end
                check("d4_latency", 32'(lat4), 32'd2);
              end
      end
      begin : sweep8
        int lat8;
        for (int ia = 0; ia < 8; ia++)
          for (int ib = 0; ib < 8; ib++)
            for (int c = 0; c < 2; c++)
              for (int s = 0; s < 2; s++) begin
                s8.a = vals[ia]; s8.b = vals[ib]; s8.cin = c[0]; s8.sub = s[0];
                s8.start = 1'b1;
                q8.push_back(model(vals[ia], vals[ib], c[0], s[0]));
                @(posedge clk);
                @(negedge clk);
                s8.start = 1'b0;
                lat8 = 0;
                while (s8.done !== 1'b1 && lat8 < 10) begin
                  @(posedge clk);
                  lat8++;
                  @(negedge clk);
                end
                check("d8_latency", 32'(lat8), 32'd1);
              end
      end
    join

    repeat (4) @(negedge clk);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);
    check("q8_drained", 32'(q8.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
